// File: rtl/smpl_seq_queue_pkg.sv
// Shared constants and types for the stereo sample sequencing queue.
package smpl_seq_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int DEPTH_DEF    = 1024;
    localparam int NUM_TAPS_DEF = 1021;
    localparam int PTR_W_DEF    = $clog2(DEPTH_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RD    = 2'd2,
        GAP   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/smpl_seq_queue_dpram.sv
// Simple dual-port sample memory: one write port, one registered read port.
// Left and right samples are packed into one word so a single address serves both channels.
module smpl_dpram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage array; intentionally never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value when not enabled so the queue outputs hold between bursts.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/smpl_seq_queue.sv
// Stereo circular sample queue feeding the FIR filter. Every new sample, once the
// queue holds a full window, triggers an oldest-to-newest readout burst of NUM_TAPS samples.
module smpl_seq_queue
    import smpl_seq_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NUM_TAPS = NUM_TAPS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrt_smpl,
    input  logic [DATA_W-1:0] lft_smpl,
    input  logic [DATA_W-1:0] rght_smpl,
    output logic              sequencing,
    output logic [DATA_W-1:0] lft_out,
    output logic [DATA_W-1:0] rght_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(NUM_TAPS + 1);

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] TAPS_PTR  = PTR_W'(NUM_TAPS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TAPS_CNT  = CNT_W'(NUM_TAPS);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_TAPS - 1);

    seq_state_t state_q, state_d;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic [PTR_W-1:0] start_q, start_d;
    logic [PTR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

    logic             wr_en;
    logic             rd_en;
    logic             consume;
    logic [PTR_W-1:0] wr_ptr_inc;
    logic [2*DATA_W-1:0] rd_data;

    assign wr_en      = wrt_smpl && !rst;
    assign wr_ptr_inc = wr_ptr_q + PTR_ONE;

    // Sequencer next state: prime the registered read, stream NUM_TAPS words, and when another
    // window is already waiting, load its start address on the way into the one-cycle gap so the
    // gap cycle itself primes the next burst.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_cnt_d  = rd_cnt_q;
        rd_en     = 1'b0;
        consume   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d   = PRIME;
                    rd_addr_d = start_q;
                    consume   = 1'b1;
                end
            end
            PRIME: begin
                state_d   = RD;
                rd_en     = 1'b1;
                rd_addr_d = rd_addr_q + PTR_ONE;
                rd_cnt_d  = '0;
            end
            RD: begin
                if (rd_cnt_q == LAST_CNT) begin
                    if (pending_q) begin
                        state_d   = GAP;
                        rd_addr_d = start_q;
                        consume   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    rd_en     = 1'b1;
                    rd_addr_d = rd_addr_q + PTR_ONE;
                    rd_cnt_d  = rd_cnt_q + CNT_ONE;
                end
            end
            GAP: begin
                state_d   = RD;
                rd_en     = 1'b1;
                rd_addr_d = rd_addr_q + PTR_ONE;
                rd_cnt_d  = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write side: advance the write pointer, saturate the fill count, and latch the newest window
    // start; a new write overrides a same-cycle consume so the newest window is never lost.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        start_d   = start_q;
        pending_d = pending_q;
        if (consume) begin
            pending_d = 1'b0;
        end
        if (wrt_smpl) begin
            wr_ptr_d = wr_ptr_inc;
            if (cnt_q != TAPS_CNT) begin
                cnt_d = cnt_q + CNT_ONE;
            end
            if (cnt_q >= LAST_CNT) begin
                pending_d = 1'b1;
                start_d   = wr_ptr_inc - TAPS_PTR;
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            rd_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    // Write-side registers; reset empties the queue logically while leaving memory untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            start_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            pending_q <= pending_d;
        end
    end

    smpl_dpram #(
        .WIDTH (2 * DATA_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata ({lft_smpl, rght_smpl}),
        .re    (rd_en),
        .raddr (rd_addr_q),
        .rdata (rd_data)
    );

    assign sequencing = (state_q == RD);
    assign lft_out    = rd_data[2*DATA_W-1:DATA_W];
    assign rght_out   = rd_data[DATA_W-1:0];

endmodule
